mod_iq_upconv: RTL and testbench

//  Consumes the 2-bit I/Q Gray symbols produced by the modulator serial-to-parallel stage.

---
 rtl/mod_iq_upconv.sv | 78 +++++++
 tb/tb_mod_iq_upconv.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mod_iq_upconv.sv
// mod_iq_upconv: maps Gray I/Q symbols to 4-level amplitudes, ramps linearly between
// successive symbols and mixes the result onto an fs/4 carrier, one real sample per clock.
module mod_iq_upconv #(
    parameter int SPS_LOG2 = 2,
    parameter int AMP      = 16,
    parameter int OUT_W    = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              sym_i,
    input  logic [1:0]              sym_q,
    input  logic                    sym_stb,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_valid
);
    localparam int IW = OUT_W + SPS_LOG2 + 2;
    localparam logic [SPS_LOG2-1:0] K_MAX = '1;

    if (3 * AMP > 2 ** (OUT_W - 1) - 1) begin : g_amp_chk
        $error("mod_iq_upconv: 3*AMP does not fit in OUT_W");
    end

    function automatic logic signed [OUT_W-1:0] map(input logic [1:0] g);
        map = g == 2'b00 ? OUT_W'(-3 * AMP) :
              g == 2'b01 ? OUT_W'(-AMP) :
              g == 2'b11 ? OUT_W'(AMP) : OUT_W'(3 * AMP);
    endfunction

    // Ramp point k+1 of SPS from a toward b; arithmetic shift gives floor rounding.
    function automatic logic signed [OUT_W-1:0] interp(input logic signed [OUT_W-1:0] a,
                                                       input logic signed [OUT_W-1:0] b,
                                                       input logic [SPS_LOG2-1:0] k);
        logic signed [IW-1:0] kp;
        logic signed [IW-1:0] d;
        kp = IW'(k) + IW'(1);
        d = (IW'(b) - IW'(a)) * kp;
        interp = a + OUT_W'(d >>> SPS_LOG2);
    endfunction

    logic signed [OUT_W-1:0] prev_i, prev_q, cur_i, cur_q, s_i, s_q;
    logic [SPS_LOG2-1:0]     k;
    logic [1:0]              p;
    logic                    v1, v2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_i     <= '0;
            prev_q     <= '0;
            cur_i      <= '0;
            cur_q      <= '0;
            k          <= K_MAX;
            s_i        <= '0;
            s_q        <= '0;
            p          <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (sym_stb) begin
                prev_i <= cur_i;
                prev_q <= cur_q;
                cur_i  <= map(sym_i);
                cur_q  <= map(sym_q);
                k      <= '0;
            end else if (k != K_MAX) begin
                k <= k + 1'b1;
            end
            s_i        <= interp(prev_i, cur_i, k);
            s_q        <= interp(prev_q, cur_q, k);
            p          <= p + 2'd1;
            dout       <= p == 2'd0 ? s_i : p == 2'd1 ? -s_q : p == 2'd2 ? -s_i : s_q;
            v1         <= v1 | sym_stb;
            v2         <= v1;
            dout_valid <= v2;
        end
    end
endmodule

// File: tb/tb_mod_iq_upconv.sv
// tb_mod_iq_upconv: directed I/Q ramps with hand-computed interpolation points; a
// scoreboard keyed by cycle number holds the expected carrier-mixed sample for each cycle.
module tb_mod_iq_upconv;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        sym_i = '0, sym_q = '0;
    logic              sym_stb = 1'b0;
    logic signed [11:0] dout;
    logic              dout_valid;

    typedef struct {
        int cyc;
        int d;
        bit v;
    } item_t;

    item_t sb[$];
    int    cyc = 0, r = 0, n_vec = 0, n_bad = 0;
    bit    seen = 1'b0;

    mod_iq_upconv #(.SPS_LOG2(2), .AMP(16), .OUT_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .sym_i(sym_i), .sym_q(sym_q),
        .sym_stb(sym_stb), .dout(dout), .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int mix(input int si, input int sq, input int p);
        return p == 0 ? si : p == 1 ? -sq : p == 2 ? -si : sq;
    endfunction

    // esi/esq: interpolated level produced from the state after this cycle's edge,
    // which reaches dout three cycles later on carrier phase (cyc+1-r) mod 4.
    task automatic step(input bit stb, input logic [1:0] i, input logic [1:0] q,
                        input int esi, input int esq);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sym_stb = stb;
        sym_i = i;
        sym_q = q;
        if (stb) seen = 1'b1;
        sb.push_back('{cyc + 3, mix(esi, esq, (cyc + 1 - r) & 3), seen});
    endtask

    task automatic rst_cyc();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sym_stb = 1'($urandom);
        sym_i = 2'($urandom);
        sym_q = 2'($urandom);
        while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
        for (int d = 1; d <= 3; d++) sb.push_back('{cyc + d, 0, 1'b0});
        r = cyc;
        seen = 1'b0;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            item_t e;
            e = sb.pop_front();
            n_vec++;
            if (e.cyc != cyc || int'(dout) != e.d || dout_valid !== e.v) begin
                n_bad++;
                $display("FAIL cyc%0d dout/valid: got %0d/%b, expected %0d/%b (for cyc %0d)",
                         cyc, dout, dout_valid, e.d, e.v, e.cyc);
            end
        end
    end

    initial begin
        // reset with random stimulus
        repeat (3) rst_cyc();
        step(0, 2'b00, 2'b00, 0, 0);
        // nominal strobes 10/10 every 4 clk
        step(1, 2'b10, 2'b10, 12, 12);
        step(0, 2'b00, 2'b00, 24, 24);
        step(0, 2'b00, 2'b00, 36, 36);
        step(0, 2'b00, 2'b00, 48, 48);
        for (int n = 0; n < 3; n++) begin
            step(1, 2'b10, 2'b10, 48, 48);
            for (int j = 0; j < 3; j++) step(0, 2'b11, 2'b01, 48, 48);
        end
        // I from +48 to -48, settle, then back to +48
        step(1, 2'b00, 2'b10, 24, 48);
        step(0, 2'b00, 2'b00, 0, 48);
        step(0, 2'b00, 2'b00, -24, 48);
        step(0, 2'b00, 2'b00, -48, 48);
        step(1, 2'b00, 2'b10, -48, 48);
        for (int j = 0; j < 3; j++) step(0, 2'b00, 2'b00, -48, 48);
        step(1, 2'b10, 2'b10, -24, 48);
        step(0, 2'b00, 2'b00, 0, 48);
        step(0, 2'b00, 2'b00, 24, 48);
        step(0, 2'b00, 2'b00, 48, 48);
        // early strobe: settle at -48, go toward +48, redirect to -16 two clk later
        step(1, 2'b00, 2'b10, 24, 48);
        step(0, 2'b00, 2'b00, 0, 48);
        step(0, 2'b00, 2'b00, -24, 48);
        step(0, 2'b00, 2'b00, -48, 48);
        step(1, 2'b00, 2'b10, -48, 48);
        for (int j = 0; j < 3; j++) step(0, 2'b00, 2'b00, -48, 48);
        step(1, 2'b10, 2'b10, -24, 48);
        step(0, 2'b00, 2'b00, 0, 48);
        step(1, 2'b01, 2'b10, 32, 48);
        step(0, 2'b00, 2'b00, 16, 48);
        step(0, 2'b00, 2'b00, 0, 48);
        step(0, 2'b00, 2'b00, -16, 48);
        // late strobe: one symbol, then 20 clk without strobes (k saturates)
        step(1, 2'b11, 2'b01, -8, 32);
        step(0, 2'b00, 2'b00, 0, 16);
        step(0, 2'b00, 2'b00, 8, 0);
        step(0, 2'b00, 2'b00, 16, -16);
        for (int j = 0; j < 17; j++) step(0, 2'($urandom), 2'($urandom), 16, -16);
        // reset mid-ramp, then a fresh ramp from 0
        step(1, 2'b10, 2'b00, 24, -24);
        step(0, 2'b00, 2'b00, 32, -32);
        rst_cyc();
        step(0, 2'b00, 2'b00, 0, 0);
        step(1, 2'b10, 2'b11, 12, 4);
        step(0, 2'b00, 2'b00, 24, 8);
        step(0, 2'b00, 2'b00, 36, 12);
        step(0, 2'b00, 2'b00, 48, 16);
        // back-to-back strobes each advance prev/cur
        step(1, 2'b00, 2'b11, 24, 16);
        step(1, 2'b01, 2'b11, -40, 16);
        step(0, 2'b00, 2'b00, -32, 16);
        step(0, 2'b00, 2'b00, -24, 16);
        step(0, 2'b00, 2'b00, -16, 16);
        for (int j = 0; j < 3; j++) step(0, 2'b00, 2'b00, -16, 16);
        repeat (5) @(posedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected samples never checked, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
